// File: rtl/sm83_bus_pkg.sv
// Shared constants and types for the SM83 bus controller and OAM DMA engine.
// Optional feature macro: OAM_DMA_ECHO_MAP_EN (fold echo-RAM source pages).
package sm83_bus_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam int unsigned DMA_LEN      = 160;
  localparam logic [7:0]  DMA_LAST_IDX = 8'(DMA_LEN - 1);
  localparam logic [7:0]  OPEN_BUS     = 8'hFF;
  localparam logic [7:0]  SRC_RST      = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    DRAIN
  } dma_state_t;

  // Source page actually driven on the bus; the register readback stays raw.
  function automatic logic [7:0] dma_src_eff(input logic [7:0] src);
`ifdef OAM_DMA_ECHO_MAP_EN
    return (src >= 8'hE0) ? (src & 8'hDF) : src;
`else
    return src;
`endif
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA sequencer: state, byte index and the one-cycle read-to-write pipeline.
// Reads for index i are issued in XFER; the OAM write of i follows a cycle later
// with the synchronous memory's data.
module oam_dma_engine
  import sm83_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] bus_din_i,
  output logic       rd_en_o,
  output logic [7:0] rd_idx_o,
  output logic       dma_active_o,
  output logic [7:0] oam_addr_o,
  output logic [7:0] oam_wdata_o,
  output logic       oam_we_o
);

  dma_state_t state_q;
  logic [7:0] idx_q;
  logic [7:0] idx_d;
  logic [7:0] oam_addr_q;
  logic       oam_we_q;
  logic       active_q;

  assign idx_d = idx_q + 8'd1;

  // Single FSM: a start always wins and re-arms the copy from index 0.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      oam_addr_q <= '0;
      oam_we_q   <= 1'b0;
      active_q   <= 1'b0;
    end else if (start_i) begin
      state_q  <= SETUP;
      idx_q    <= '0;
      oam_we_q <= 1'b0;
      active_q <= 1'b1;
    end else begin
      oam_we_q <= (state_q == XFER);
      if (state_q == XFER) begin
        oam_addr_q <= idx_q;
      end
      case (state_q)
        IDLE:  ;
        SETUP: state_q <= XFER;
        XFER: begin
          if (idx_q == DMA_LAST_IDX) begin
            state_q <= DRAIN;
          end else begin
            idx_q <= idx_d;
          end
        end
        DRAIN: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_en_o      = (state_q == XFER);
  assign rd_idx_o     = idx_q;
  assign dma_active_o = active_q;
  // A restart in the same cycle abandons whatever write is in flight.
  assign oam_we_o     = oam_we_q & ~start_i;
  assign oam_addr_o   = oam_addr_q;
  assign oam_wdata_o  = oam_we_o ? bus_din_i : 8'h00;

endmodule

// File: rtl/oam_dma_ctrl.sv
// Bus controller: 0xFF46 source register, CPU/DMA bus muxing and CPU lockout.
// Optional feature macro: OAM_DMA_ECHO_MAP_EN (echo-RAM source folding).
module oam_dma_ctrl
  import sm83_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_oe,
  input  logic        cpu_wr,
  input  logic        cpu_cs,
  output logic [7:0]  cpu_din,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_oe,
  output logic        bus_wr,
  output logic        bus_cs,
  input  logic [7:0]  bus_din,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        dma_active
);

  logic       reg_hit;
  logic       dma_start;
  logic       rd_en;
  logic [7:0] rd_idx;
  logic [7:0] src_q;
  logic [7:0] src_d;
  logic [7:0] src_eff;

  assign reg_hit   = cpu_cs && (cpu_addr == DMA_REG_ADDR);
  assign dma_start = reg_hit && cpu_wr;
  assign src_d     = dma_start ? cpu_dout : src_q;
  assign src_eff   = dma_src_eff(src_q);

  // Source register, serviced in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= SRC_RST;
    end else begin
      src_q <= src_d;
    end
  end

  oam_dma_engine u_engine (
    .clk          (clk),
    .rst          (rst),
    .start_i      (dma_start),
    .bus_din_i    (bus_din),
    .rd_en_o      (rd_en),
    .rd_idx_o     (rd_idx),
    .dma_active_o (dma_active),
    .oam_addr_o   (oam_addr),
    .oam_wdata_o  (oam_wdata),
    .oam_we_o     (oam_we)
  );

  // Bus ownership: DMA reads in XFER, otherwise CPU pass-through unless locked out.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    bus_addr = cpu_addr;
    bus_dout = cpu_dout;
    bus_oe   = cpu_oe;
    bus_wr   = cpu_wr;
    bus_cs   = cpu_cs;
    if (rd_en) begin
      bus_addr = {src_eff, rd_idx};
      bus_dout = 8'h00;
      bus_oe   = 1'b1;
      bus_wr   = 1'b0;
      bus_cs   = 1'b1;
    end else if (dma_active || reg_hit) begin
      bus_oe = 1'b0;
      bus_wr = 1'b0;
      bus_cs = 1'b0;
    end
  end

  assign cpu_din = reg_hit    ? src_q    :
                   dma_active ? OPEN_BUS : bus_din;

endmodule
